// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared definitions for the sequential binary-to-BCD converter.
//   state_t           : converter FSM encoding (idle / op / done).
//   digits_for_width  : decimal digit count needed to show any W-bit unsigned
//                       value without overflow; use it to size D for a given W.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int digits_for_width(input int w);
        longint unsigned max_val;
        int              n;
        max_val = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        n       = 1;
        while (max_val >= 64'd10) begin
            max_val = max_val / 64'd10;
            n       = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_adj3.sv
// bcd_adj3 -- double-dabble digit correction.
//   din  : 4-bit working digit before the shift
//   dout : din + 3 (mod 16) when din >= 5, else din unchanged
module bcd_adj3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential shift-and-add-3 binary to packed BCD converter.
// Sits directly downstream of the divider: bin is driven from quo and start
// from the divider's done_tick.
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high
//   start     : conversion request, sampled only while idle
//   bin       : W-bit unsigned operand, captured at acceptance
//   ready     : high exactly while idle
//   done_tick : one-cycle pulse in the cycle after the result registers load
//   bcd       : D packed BCD digits, digit 0 in bits [3:0]
//   ndig      : significant digit count (1 for zero, D on overflow)
//   ovf       : bin did not fit in D digits; bcd then holds bin mod 10^D
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [W-1:0]             bin,
    output logic                     ready,
    output logic                     done_tick,
    output logic [4*D-1:0]           bcd,
    output logic [$clog2(D+1)-1:0]   ndig,
    output logic                     ovf
);

    localparam int CW = $clog2(W + 1);
    localparam int NW = $clog2(D + 1);

    state_t          state_q, state_d;
    logic [W-1:0]    bin_q, bin_d;
    logic [4*D-1:0]  work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_acc_q, ovf_acc_d;
    logic [4*D-1:0]  bcd_q, bcd_d;
    logic [NW-1:0]   ndig_q, ndig_d;
    logic            ovf_q, ovf_d;

    logic [4*D-1:0]  adj_work;
    logic [4*D-1:0]  shift_work;
    logic            ovf_next;
    logic            last_shift;
    logic [NW-1:0]   ndig_calc;

    // Per-digit add-3 correction ahead of the shift.
    for (genvar g = 0; g < D; g++) begin : g_adj
        bcd_adj3 u_adj (
            .din  (work_q[4*g +: 4]),
            .dout (adj_work[4*g +: 4])
        );
    end

    // Adjusted register shifted left with the binary MSB entering digit 0;
    // the bit leaving the top digit would belong to a digit we do not have.
    assign shift_work = {adj_work[4*D-2:0], bin_q[W-1]};
    assign ovf_next   = ovf_acc_q | adj_work[4*D-1];
    assign last_shift = (cnt_q == CW'(1));

    // Significant digits of the value about to be loaded; zero reports 1.
    always_comb begin
        ndig_calc = NW'(1);
        for (int i = 0; i < D; i++) begin
            if (shift_work[4*i +: 4] != 4'd0) begin
                ndig_calc = NW'(i + 1);
            end
        end
    end

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = start ? ST_OP : ST_IDLE;
            ST_OP:   state_d = last_shift ? ST_DONE : ST_OP;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        bin_d     = bin_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        ndig_d    = ndig_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d     = bin;
                    work_d    = '0;
                    cnt_d     = CW'(W);
                    ovf_acc_d = 1'b0;
                end
            end
            ST_OP: begin
                bin_d     = {bin_q[W-2:0], 1'b0};
                work_d    = shift_work;
                cnt_d     = cnt_q - CW'(1);
                ovf_acc_d = ovf_next;
                // Result registers change only on the final shift so they
                // hold the previous result throughout the conversion.
                if (last_shift) begin
                    bcd_d  = shift_work;
                    ovf_d  = ovf_next;
                    ndig_d = ovf_next ? NW'(D) : ndig_calc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q     <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ndig_q    <= NW'(1);
            ovf_q     <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ndig_q    <= ndig_d;
            ovf_q     <= ovf_d;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        ready     = (state_q == ST_IDLE);
        done_tick = (state_q == ST_DONE);
    end

    assign bcd  = bcd_q;
    assign ndig = ndig_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start2;
    logic [7:0]  bin, bin2;
    logic        ready, done_tick, ovf;
    logic [11:0] bcd;
    logic [1:0]  ndig;
    logic        ready2, done2, ovf2;
    logic [7:0]  bcd2;
    logic [1:0]  ndig2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [11:0] bcd;
        int          ndig;
        bit          ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb2_q[$];
    exp_t last_exp;

    always #5 clk = ~clk;

    bin2bcd_seq #(.W(8), .D(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin       (bin),
        .ready     (ready),
        .done_tick (done_tick),
        .bcd       (bcd),
        .ndig      (ndig),
        .ovf       (ovf)
    );

    bin2bcd_seq #(.W(8), .D(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .start     (start2),
        .bin       (bin2),
        .ready     (ready2),
        .done_tick (done2),
        .bcd       (bcd2),
        .ndig      (ndig2),
        .ovf       (ovf2)
    );

    // Reference: decimal digits by division, independent of double-dabble.
    function automatic exp_t model(input int v, input int nd);
        exp_t e;
        int   p;
        int   digit;
        e.bcd  = '0;
        e.ndig = 1;
        p      = 1;
        for (int i = 0; i < nd; i++) begin
            digit = (v / p) % 10;
            e.bcd[4*i +: 4] = 4'(digit);
            if (digit != 0) e.ndig = i + 1;
            p = p * 10;
        end
        e.ovf = (v > p - 1);
        if (e.ovf) e.ndig = nd;
        return e;
    endfunction

    task automatic test_reset;
        reset  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        bin    = '0;
        bin2   = '0;
        repeat (2) @(negedge clk);
        total++; if (ready !== 1'b1)      begin bad++; $display("FAIL reset_ready: got=%b exp=1", ready); end
        total++; if (done_tick !== 1'b0)  begin bad++; $display("FAIL reset_done: got=%b exp=0", done_tick); end
        total++; if (bcd !== 12'h000)     begin bad++; $display("FAIL reset_bcd: got=%h exp=000", bcd); end
        total++; if (ndig !== 2'd1)       begin bad++; $display("FAIL reset_ndig: got=%0d exp=1", ndig); end
        total++; if (ovf !== 1'b0)        begin bad++; $display("FAIL reset_ovf: got=%b exp=0", ovf); end
        total++; if (ready2 !== 1'b1 || bcd2 !== 8'h00 || ndig2 !== 2'd1 || ovf2 !== 1'b0)
            begin bad++; $display("FAIL reset_dut2: ready=%b bcd=%h ndig=%0d ovf=%b exp 1/00/1/0", ready2, bcd2, ndig2, ovf2); end
        reset    = 1'b0;
        last_exp = model(0, 3);
    endtask

    // One conversion on the D=3 instance. With disturb set, bin changes and
    // start pulses again mid-conversion; neither may have any effect.
    task automatic convert(input logic [7:0] v, input bit disturb, input string name);
        exp_t e;
        int   cyc;
        int   rlow;
        int   extra;
        bit   seen;
        bit   unstable;
        sb_q.push_back(model(int'(v), 3));
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        rlow     = 0;
        seen     = 1'b0;
        unstable = 1'b0;
        while (cyc <= 40 && !seen) begin
            if (done_tick) begin
                seen = 1'b1;
            end else begin
                if (!ready) rlow++;
                if (bcd !== last_exp.bcd || int'(ndig) != last_exp.ndig || ovf !== last_exp.ovf) unstable = 1'b1;
                if (disturb && cyc == 3) begin bin = 8'd7; start = 1'b1; end
                if (disturb && cyc == 4) start = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        total++;
        if (unstable) begin bad++; $display("FAIL %s_hold: outputs changed during op, exp bcd=%h", name, last_exp.bcd); end
        total++;
        if (!seen) begin
            bad++; $display("FAIL %s_timeout: no done_tick within %0d cycles", name, cyc);
            start = 1'b0;
            void'(sb_q.pop_back());
            return;
        end
        if (!ready) rlow++;
        total++; if (cyc != 9)  begin bad++; $display("FAIL %s_latency: got=%0d exp=9", name, cyc); end
        total++; if (rlow != 9) begin bad++; $display("FAIL %s_ready_low: got=%0d exp=9", name, rlow); end
        if (sb_q.size() == 0) begin
            bad++; $display("FAIL %s_scoreboard: done_tick with nothing expected", name);
        end else begin
            e = sb_q.pop_front();
            total++; if (bcd !== e.bcd)         begin bad++; $display("FAIL %s_bcd: got=%h exp=%h", name, bcd, e.bcd); end
            total++; if (int'(ndig) != e.ndig)  begin bad++; $display("FAIL %s_ndig: got=%0d exp=%0d", name, ndig, e.ndig); end
            total++; if (ovf !== e.ovf)         begin bad++; $display("FAIL %s_ovf: got=%b exp=%b", name, ovf, e.ovf); end
            last_exp = e;
        end
        @(negedge clk);
        total++;
        if (done_tick !== 1'b0 || ready !== 1'b1) begin
            bad++; $display("FAIL %s_pulse: done_tick=%b ready=%b exp 0/1", name, done_tick, ready);
        end
        if (disturb) begin
            extra = 0;
            repeat (12) begin
                if (done_tick || !ready) extra++;
                @(negedge clk);
            end
            total++;
            if (extra != 0) begin bad++; $display("FAIL %s_queued: busy/done cycles got=%0d exp=0", name, extra); end
        end
    endtask

    task automatic test_basic;
        convert(8'd0,   1'b0, "zero");
        convert(8'd255, 1'b0, "max");
        convert(8'd9,   1'b0, "nine");
        convert(8'd10,  1'b0, "ten");
    endtask

    task automatic test_ignore_restart;
        convert(8'd200, 1'b1, "restart");
    endtask

    task automatic test_chain;
        int dvnd;
        int dvsr;
        int quo;
        dvnd = 200;
        dvsr = 7;
        quo  = dvnd / dvsr;
        convert(8'(quo), 1'b0, "chain");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            convert(8'($urandom_range(0, 255)), 1'b0, "b2b");
        end
        convert(8'd99,  1'b0, "b2b_99");
        convert(8'd100, 1'b0, "b2b_100");
    endtask

    task automatic test_reset_mid_op;
        exp_t e;
        int   cyc;
        int   pulses;
        @(negedge clk);
        bin   = 8'd255;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (ready !== 1'b1 || done_tick !== 1'b0)
            begin bad++; $display("FAIL midreset_ctl: ready=%b done=%b exp 1/0", ready, done_tick); end
        total++; if (bcd !== 12'h000 || ndig !== 2'd1 || ovf !== 1'b0)
            begin bad++; $display("FAIL midreset_out: bcd=%h ndig=%0d ovf=%b exp 000/1/0", bcd, ndig, ovf); end
        last_exp = model(0, 3);
        @(negedge clk);
        reset = 1'b0;
        bin   = 8'd42;
        start = 1'b1;
        sb_q.push_back(model(42, 3));
        @(negedge clk);
        start = 1'b0;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL first_edge_accept: ready=%b exp=0", ready); end
        cyc    = 1;
        pulses = 0;
        while (cyc <= 40 && !done_tick) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (!done_tick) begin
            bad++; $display("FAIL midreset_timeout: no done_tick in %0d cycles", cyc);
            void'(sb_q.pop_back());
            return;
        end
        total++; if (cyc != 9) begin bad++; $display("FAIL midreset_latency: got=%0d exp=9", cyc); end
        e = sb_q.pop_front();
        total++; if (bcd !== e.bcd || int'(ndig) != e.ndig || ovf !== e.ovf)
            begin bad++; $display("FAIL midreset_result: bcd=%h ndig=%0d ovf=%b exp %h/%0d/%b", bcd, ndig, ovf, e.bcd, e.ndig, e.ovf); end
        last_exp = e;
        repeat (12) begin
            @(negedge clk);
            if (done_tick) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL midreset_stray_done: got=%0d exp=0", pulses); end
    endtask

    task automatic test_overflow;
        int   vals[4] = '{123, 200, 99, 100};
        exp_t e;
        int   cyc;
        for (int i = 0; i < 4; i++) begin
            sb2_q.push_back(model(vals[i], 2));
            @(negedge clk);
            bin2   = 8'(vals[i]);
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            cyc    = 1;
            while (cyc <= 40 && !done2) begin
                @(negedge clk);
                cyc++;
            end
            total++;
            if (!done2) begin
                bad++; $display("FAIL ovf_timeout: value=%0d no done_tick", vals[i]);
                void'(sb2_q.pop_back());
            end else begin
                e = sb2_q.pop_front();
                total++; if (bcd2 !== e.bcd[7:0])    begin bad++; $display("FAIL ovf_bcd: value=%0d got=%h exp=%h", vals[i], bcd2, e.bcd[7:0]); end
                total++; if (int'(ndig2) != e.ndig)  begin bad++; $display("FAIL ovf_ndig: value=%0d got=%0d exp=%0d", vals[i], ndig2, e.ndig); end
                total++; if (ovf2 !== e.ovf)         begin bad++; $display("FAIL ovf_flag: value=%0d got=%b exp=%b", vals[i], ovf2, e.ovf); end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_restart();
        test_chain();
        test_overflow();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
